// File: rtl/if_id_prefetch_unit.sv
// Sequential instruction prefetcher feeding a registered MIPS decode stage.
// A small FIFO absorbs variable memory latency; branches flush the FIFO and squash in-flight fetches.
module if_id_prefetch_unit #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    QUEUE_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(32'h0040_0000)
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          fetch_req,
    output logic [ADDR_WIDTH-1:0]         instruction_address,
    input  logic [31:0]                   instruction_bus,
    input  logic                          instruction_valid,
    input  logic                          stall,
    input  logic                          branch,
    input  logic [ADDR_WIDTH-1:0]         branch_target,
    output logic                          id_valid,
    output logic [ADDR_WIDTH-1:0]         pc,
    output logic [5:0]                    op,
    output logic [4:0]                    rs,
    output logic [4:0]                    rt,
    output logic [4:0]                    rd,
    output logic [4:0]                    shamt,
    output logic [5:0]                    funct,
    output logic [15:0]                   immediate,
    output logic [25:0]                   target,
    output logic [4:0]                    rw,
    output logic                          register_write,
    output logic                          branch_o,
    output logic [$clog2(QUEUE_DEPTH):0]  queue_count
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] QD_L = (CW+1)'(QUEUE_DEPTH);

    logic [ADDR_WIDTH-1:0] r_fetch_pc, r_resp_pc;
    logic [CW-1:0]         r_outstanding, r_discard, r_count;
    logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [ADDR_WIDTH-1:0] r_q_addr  [QUEUE_DEPTH];
    logic [31:0]           r_q_instr [QUEUE_DEPTH];

    logic                  r_id_valid, r_id_we, r_branch_o;
    logic [ADDR_WIDTH-1:0] r_id_pc;
    logic [31:0]           r_id_instr;
    logic [4:0]            r_id_rw;

    logic                  w_resp, w_drop, w_push, w_pop, w_fetch;
    logic [CW:0]           w_inflight;
    logic [31:0]           w_head_instr;
    logic [ADDR_WIDTH-1:0] w_head_pc;
    logic [4:0]            w_rw;
    logic                  w_we;

    // A response with nothing outstanding is a protocol violation and is ignored.
    assign w_resp     = instruction_valid && (r_outstanding != '0);
    assign w_drop     = w_resp && (r_discard != '0);
    assign w_push     = w_resp && !w_drop && !branch;
    assign w_pop      = !stall && !branch && (r_count != '0);
    assign w_inflight = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_fetch    = !rst && !branch && (w_inflight < QD_L);

    assign fetch_req           = w_fetch;
    assign instruction_address = r_fetch_pc;
    assign queue_count         = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else if (branch) begin
            // Everything still in flight becomes garbage; the response landing now is dropped too.
            r_fetch_pc    <= branch_target;
            r_resp_pc     <= branch_target;
            r_outstanding <= r_outstanding - CW'(w_resp);
            r_discard     <= r_outstanding - CW'(w_resp);
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            if (w_fetch)
                r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(4);
            r_outstanding <= r_outstanding + CW'(w_fetch) - CW'(w_resp);
            r_discard     <= r_discard - CW'(w_drop);
            if (w_push) begin
                r_wr_ptr  <= r_wr_ptr + PW'(1);
                r_resp_pc <= r_resp_pc + ADDR_WIDTH'(4);
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_q_addr[r_wr_ptr]  <= r_resp_pc;
            r_q_instr[r_wr_ptr] <= instruction_bus;
        end
    end

    assign w_head_instr = r_q_instr[r_rd_ptr];
    assign w_head_pc    = r_q_addr[r_rd_ptr];

    always_comb begin
        w_rw = 5'd0;
        w_we = 1'b0;
        if (w_head_instr[31:26] == 6'h00) begin
            w_rw = w_head_instr[15:11];
            w_we = (w_head_instr[5:0] != 6'h08);
        end else if (w_head_instr[31:26] == 6'h03) begin
            w_rw = 5'd31;
            w_we = 1'b1;
        end else if (w_head_instr[31:26] inside {[6'h08:6'h0F], [6'h20:6'h25]}) begin
            w_rw = w_head_instr[20:16];
            w_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        r_branch_o <= !rst && branch;
        if (rst || branch) begin
            r_id_valid <= 1'b0;
            r_id_pc    <= '0;
            r_id_instr <= '0;
            r_id_rw    <= '0;
            r_id_we    <= 1'b0;
        end else if (!stall) begin
            if (r_count != '0) begin
                r_id_valid <= 1'b1;
                r_id_pc    <= w_head_pc;
                r_id_instr <= w_head_instr;
                r_id_rw    <= w_rw;
                r_id_we    <= w_we;
            end else begin
                r_id_valid <= 1'b0;
            end
        end
    end

    assign id_valid       = r_id_valid;
    assign pc             = r_id_pc;
    assign op             = r_id_instr[31:26];
    assign rs             = r_id_instr[25:21];
    assign rt             = r_id_instr[20:16];
    assign rd             = r_id_instr[15:11];
    assign shamt          = r_id_instr[10:6];
    assign funct          = r_id_instr[5:0];
    assign immediate      = r_id_instr[15:0];
    assign target         = r_id_instr[25:0];
    assign rw             = r_id_rw;
    assign register_write = r_id_we;
    assign branch_o       = r_branch_o;

endmodule

// File: tb/tb_if_id_prefetch_unit.sv
// Scoreboard bench: stimulus fills an expected-instruction queue, a monitor pops it on every ID advance.
module tb_if_id_prefetch_unit;
    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst, fetch_req, instruction_valid, stall, branch;
    logic [31:0] instruction_address, instruction_bus, branch_target, pc;
    logic        id_valid, register_write, branch_o;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt, rw;
    logic [15:0] immediate;
    logic [25:0] target;
    logic [2:0]  queue_count;

    if_id_prefetch_unit #(.ADDR_WIDTH(32), .QUEUE_DEPTH(4), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .instruction_address(instruction_address),
        .instruction_bus(instruction_bus), .instruction_valid(instruction_valid),
        .stall(stall), .branch(branch), .branch_target(branch_target),
        .id_valid(id_valid), .pc(pc), .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .funct(funct), .immediate(immediate), .target(target), .rw(rw),
        .register_write(register_write), .branch_o(branch_o), .queue_count(queue_count)
    );

    initial forever #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] instr; logic [4:0] rw; logic we; } exp_t;
    typedef struct { int due; logic [31:0] data; } mreq_t;

    exp_t        sb[$];
    mreq_t       mq[$];
    logic [31:0] mem [logic [31:0]];
    logic [4:0]  mrw [logic [31:0]];
    logic        mwe [logic [31:0]];
    int          n_chk = 0, n_err = 0, n_seen = 0, lat = 1, ncyc = 0, base;
    logic [31:0] last_pc = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Unlisted addresses hold addi with rt = addr[6:2], so rw = addr[6:2], register_write = 1.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {6'h08, 5'd0, a[6:2], a[15:0]};
    endfunction

    task automatic put(input logic [31:0] a, input logic [31:0] w, input logic [4:0] r, input logic e);
        mem[a] = w; mrw[a] = r; mwe[a] = e;
    endtask

    task automatic restart(input logic [31:0] start);
        exp_t e;
        sb.delete();
        for (int i = 0; i < 64; i++) begin
            e.pc    = start + 32'(4 * i);
            e.instr = mem_word(e.pc);
            e.rw    = mrw.exists(e.pc) ? mrw[e.pc] : e.pc[6:2];
            e.we    = mwe.exists(e.pc) ? mwe[e.pc] : 1'b1;
            sb.push_back(e);
        end
    endtask

    // Memory: in-order responses, 'lat' cycles after the request, one per cycle.
    initial begin
        instruction_valid = 1'b0;
        instruction_bus   = '0;
        forever begin
            @(negedge clk);
            ncyc++;
            #2;
            if (mq.size() > 0 && mq[0].due <= ncyc) begin
                instruction_valid = 1'b1;
                instruction_bus   = mq[0].data;
                void'(mq.pop_front());
            end else begin
                instruction_valid = 1'b0;
                instruction_bus   = '0;
            end
            if (fetch_req)
                mq.push_back('{due: ncyc + lat, data: mem_word(instruction_address)});
        end
    end

    // Monitor: an edge with rst/stall/branch low and id_valid high loaded a new instruction.
    initial begin
        exp_t me;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && !stall && !branch && id_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_instr", pc, 64'hFFFF_FFFF_FFFF);
                end else begin
                    me = sb.pop_front();
                    chk("id_pc", pc, me.pc);
                    chk("id_fields", {op, rs, rt, rd, shamt, funct}, me.instr);
                    chk("id_imm_tgt", {immediate, target}, {me.instr[15:0], me.instr[25:0]});
                    chk("id_rw_we", {rw, register_write}, {me.rw, me.we});
                    last_pc = me.pc;
                    n_seen++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; stall = 1'b0; branch = 1'b0; branch_target = '0;
        put(32'h0040_0000, 32'h27bd_ffd0, 5'd29, 1'b1);
        put(32'h0040_0004, 32'h0062_1021, 5'd2,  1'b1);
        put(32'h0040_0008, 32'h0c10_0828, 5'd31, 1'b1);
        put(32'h0000_3000, 32'h03e0_0008, 5'd0,  1'b0); // jr
        put(32'h0000_3004, 32'h1043_0003, 5'd0,  1'b0); // beq
        put(32'h0000_3008, 32'hafbf_0010, 5'd0,  1'b0); // sw
        put(32'h0000_300c, 32'h8fa8_0004, 5'd8,  1'b1); // lw
        put(32'h0000_3010, 32'h0810_0000, 5'd0,  1'b0); // j
        put(32'h0000_3014, 32'h0000_1000, 5'd2,  1'b1); // sll
        put(32'h0000_3018, 32'h3c01_abcd, 5'd1,  1'b1); // lui
        put(32'h0000_301c, 32'h8082_0000, 5'd2,  1'b1); // lb
        put(32'h0000_3020, 32'h94a3_0000, 5'd3,  1'b1); // lhu
        put(32'h0000_3024, 32'h98a3_0000, 5'd0,  1'b0); // lwr
        put(32'h0000_3028, 32'h1c00_0000, 5'd0,  1'b0); // bgtz

        // Reset state and first-instruction latency at 1-cycle memory
        repeat (3) @(negedge clk);
        chk("rst_id_valid", id_valid, 0);
        chk("rst_pc", pc, 0);
        chk("rst_decode", {op, rs, rt, rd, shamt, funct, rw, register_write}, 0);
        chk("rst_qc_bo", {queue_count, branch_o}, 0);
        chk("rst_fetch_req", fetch_req, 0);
        restart(RPC);
        rst = 1'b0;
        #1;
        chk("first_fetch", {fetch_req, instruction_address}, {1'b1, RPC});
        @(negedge clk); chk("lat_c1", id_valid, 0);
        @(negedge clk); chk("lat_c2", id_valid, 0);
        @(negedge clk); chk("lat_c3", {id_valid, pc}, {1'b1, RPC});
        repeat (5) @(negedge clk);

        // Stall: ID frozen, queue fills to depth, fetch stops
        stall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("stall_hold", {id_valid, pc}, {1'b1, last_pc});
        end
        chk("stall_qc", queue_count, 4);
        chk("stall_fetch_req", fetch_req, 0);
        base = n_seen;
        stall = 1'b0;
        repeat (10) @(negedge clk);
        chk("stall_resume", n_seen - base >= 8, 1);

        // Branch with stall and a full queue: branch wins
        stall = 1'b1;
        repeat (8) @(negedge clk);
        chk("full_qc", queue_count, 4);
        branch = 1'b1; branch_target = 32'h0000_2000;
        restart(32'h0000_2000);
        @(negedge clk);
        chk("bs_state", {queue_count, id_valid, branch_o}, {3'd0, 1'b0, 1'b1});
        chk("bs_zero", {pc, op, rw, register_write}, 0);
        chk("bs_addr", instruction_address, 32'h0000_2000);
        branch = 1'b0; stall = 1'b0;
        #1;
        chk("bs_fetch", fetch_req, 1);
        @(negedge clk);
        chk("bs_bo_pulse", branch_o, 0);
        base = n_seen;
        repeat (10) @(negedge clk);
        chk("bs_progress", n_seen - base >= 6, 1);

        // Decode corner cases
        branch = 1'b1; branch_target = 32'h0000_3000;
        restart(32'h0000_3000);
        @(negedge clk);
        branch = 1'b0;
        base = n_seen;
        repeat (16) @(negedge clk);
        chk("dec_progress", n_seen - base >= 11, 1);

        // Mid-stream reset at 3-cycle latency; late responses land during reset
        lat = 3;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("mrst_state", {id_valid, queue_count, branch_o, pc}, 0);
        repeat (5) @(negedge clk);
        chk("mrst_qc", queue_count, 0);
        restart(RPC);
        rst = 1'b0;
        #1;
        chk("mrst_fetch", {fetch_req, instruction_address}, {1'b1, RPC});

        // Branch with three fetches outstanding
        repeat (3) @(negedge clk);
        chk("b3_pre", {queue_count, id_valid}, 0);
        branch = 1'b1; branch_target = 32'h1356_9874;
        restart(32'h1356_9874);
        #1;
        chk("b3_no_fetch", fetch_req, 0);
        @(negedge clk);
        chk("b3_state", {branch_o, id_valid, queue_count}, {1'b1, 1'b0, 3'd0});
        chk("b3_addr", instruction_address, 32'h1356_9874);
        branch = 1'b0;
        #1;
        chk("b3_fetch", fetch_req, 1);
        @(negedge clk);
        chk("b3_bo_pulse", branch_o, 0);
        base = n_seen;
        repeat (20) @(negedge clk);
        chk("b3_progress", n_seen - base >= 4, 1);

        // Back-to-back branches: last target wins
        branch = 1'b1; branch_target = 32'h0000_5000;
        sb.delete();
        @(negedge clk);
        chk("bb_first", {branch_o, id_valid}, {1'b1, 1'b0});
        branch_target = 32'h0000_6000;
        restart(32'h0000_6000);
        @(negedge clk);
        chk("bb_addr", {branch_o, instruction_address}, {1'b1, 32'h0000_6000});
        branch = 1'b0;
        base = n_seen;
        repeat (25) @(negedge clk);
        chk("bb_progress", n_seen - base >= 4, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
